// File: rtl/wfg_stim_pat_pkg.sv
// Shared types for the pattern stimulus source.
// Holds the FSM state encoding used by wfg_stim_pat.
package wfg_stim_pat_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } stim_state_e;

endpackage

// File: rtl/wfg_stim_pat_mem.sv
// Pattern word storage: DEPTH x AXIS_WIDTH flop array, one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module wfg_stim_pat_mem #(
   parameter int DEPTH      = 16,
   parameter int AXIS_WIDTH = 32,
   parameter int PTR_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_i,
   input  logic [PTR_W-1:0]      waddr_i,
   input  logic [AXIS_WIDTH-1:0] wdata_i,
   input  logic [PTR_W-1:0]      raddr_i,
   output logic [AXIS_WIDTH-1:0] rdata_o
);

   logic [AXIS_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wfg_stim_pat.sv
// Pattern stimulus source: streams stored pattern words on an AXI-stream
// master, one-shot or looping, with a registered output stage.
module wfg_stim_pat
   import wfg_stim_pat_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int AXIS_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ctrl_en_q_i,
   input  logic                     cfg_loop_q_i,
   input  logic [$clog2(DEPTH)-1:0] cfg_last_q_i,
   input  logic                     mem_wr_i,
   input  logic [$clog2(DEPTH)-1:0] mem_addr_i,
   input  logic [AXIS_WIDTH-1:0]    mem_wdata_i,
   input  logic                     wfg_axis_tready_i,
   output logic                     wfg_axis_tvalid_o,
   output logic                     wfg_axis_tlast_o,
   output logic [AXIS_WIDTH-1:0]    wfg_axis_tdata_o,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int PTR_W = $clog2(DEPTH);

   stim_state_e           state_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_d;
   logic                  tvalid_q;
   logic                  tlast_q;
   logic [AXIS_WIDTH-1:0] tdata_q;
   logic                  done_q;
   logic [AXIS_WIDTH-1:0] memRdata;
   logic                  hs;
   logic                  atLast;

   wfg_stim_pat_mem #(
      .DEPTH      (DEPTH),
      .AXIS_WIDTH (AXIS_WIDTH),
      .PTR_W      (PTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_i    (mem_wr_i),
      .waddr_i (mem_addr_i),
      .wdata_i (mem_wdata_i),
      .raddr_i (rd_ptr_d),
      .rdata_o (memRdata)
   );

   // Next read pointer: 0 when starting or wrapping at the last word, else
   // increment modulo DEPTH (so a pointer past a reduced last runs to the top).
   always_comb begin
      hs       = tvalid_q & wfg_axis_tready_i;
      atLast   = (rd_ptr_q == cfg_last_q_i);
      rd_ptr_d = '0;
      if ((state_q == ST_RUN) && !atLast) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rd_ptr_q <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ctrl_en_q_i) begin
                  state_q  <= ST_RUN;
                  rd_ptr_q <= '0;
                  tvalid_q <= 1'b1;
                  tdata_q  <= memRdata;
                  tlast_q  <= (rd_ptr_d == cfg_last_q_i);
               end
            end
            ST_RUN: begin
               if (!ctrl_en_q_i) begin
                  state_q  <= ST_IDLE;
                  rd_ptr_q <= '0;
                  tvalid_q <= 1'b0;
                  tlast_q  <= 1'b0;
               end else if (hs) begin
                  if (atLast && !cfg_loop_q_i) begin
                     state_q  <= ST_DONE;
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     done_q   <= 1'b1;
                  end else begin
                     rd_ptr_q <= rd_ptr_d;
                     tdata_q  <= memRdata;
                     tlast_q  <= (rd_ptr_d == cfg_last_q_i);
                  end
               end
            end
            ST_DONE: begin
               if (!ctrl_en_q_i) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign wfg_axis_tvalid_o = tvalid_q;
   assign wfg_axis_tlast_o  = tlast_q;
   assign wfg_axis_tdata_o  = tdata_q;
   assign busy_o            = (state_q == ST_RUN);
   assign done_o            = done_q;

endmodule
